idct_transpose_buf: RTL and testbench
=====================================

IDCT_TRANSPOSE_BUF -- requirements
Module: idct_transpose_buf

Interface
REQ-001 Parameter W, default 16, sample width in bits.
REQ-002 Parameter N, default 8, block edge; one block = N*N = 64 samples.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mode  input  2  readout order: 2'b00 row order; 2'b01 transposed (column) order; 2'b10/2'b11 treated as 2'b01.
REQ-006 in_valid  input  1  in_data is a valid sample.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 in_data  input  W  sample stream from idct_line, row-major order.
REQ-009 out_valid  output  1  out_data holds a valid sample.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  W  reordered sample.
REQ-012 out_last  output  1  high with the 64th sample of a block.

Function
REQ-013 An input transfer occurs when in_valid && in_ready; an output transfer when out_valid && out_ready.
REQ-014 Write side: 6-bit wr_idx, incremented on each input transfer; the sample is stored at bank[wr_bank][wr_idx].
REQ-015 Write side: after the transfer at wr_idx=63, the bank is marked FULL, wr_idx wraps to 0 and wr_bank toggles.
REQ-016 mode is sampled on the transfer with wr_idx=0 and stored with the bank; changes mid-block have no effect on that block.
REQ-017 Each bank has states EMPTY -> FILLING (first write) -> FULL (64th write) -> DRAINING (first read) -> EMPTY (64th read).
REQ-018 in_ready=1 iff bank[wr_bank] is EMPTY or FILLING.
REQ-019 Read address uses 6-bit rd_idx: row order addr=rd_idx; transposed addr={rd_idx[2:0],rd_idx[5:3]}.
REQ-020 out_data/out_valid/out_last are registered; the output register loads when !out_valid || out_ready and bank[rd_bank] is FULL or DRAINING.
REQ-021 Latency: first out_valid rises on the second rising edge after the 64th input transfer (one edge to mark FULL, one to load the output register).
REQ-022 While out_valid && !out_ready, out_data, out_last and rd_idx hold unchanged.
REQ-023 After the output load at rd_idx=63, the bank becomes EMPTY, rd_idx wraps to 0 and rd_bank toggles; with back-to-back full banks, output is gap-free.
REQ-024 If the 64th write and the 64th read of different banks occur in the same cycle, both state updates take effect.
REQ-025 A block never starts readout before all 64 of its samples are written.

Reset
REQ-026 On rst_n low: wr_idx=0, rd_idx=0, wr_bank=0, rd_bank=0, all banks EMPTY, out_valid=0, out_last=0, out_data=0, in_ready=1 on the cycle after release.
REQ-027 Reset asserted mid-block discards all partial and full blocks; memory contents need not be cleared.

Configuration
REQ-028 Macro IDCT_TRANSPOSE_PINGPONG_EN defined: two banks; writing of block k+1 overlaps readout of block k.
REQ-029 Macro undefined: one bank; wr_bank/rd_bank are tied to 0; in_ready=0 from the 64th write until the 64th read of that block completes.

Structure
REQ-030 Shared package idct_pkg holds W, N, the mode encodings (MODE_ROW=2'b00, MODE_COL=2'b01) and the bank-state enum.
REQ-031 The storage is one sub-module, idct_tbuf_ram: 64xW dual-port RAM with synchronous write and combinational read, instantiated once per bank.

Verification
REQ-032 mode=01, in_data=0..63 with continuous in_valid and out_ready=1 -> outputs 0,8,16,...,56,1,9,...,63; out_last only on 63.
REQ-033 mode=00, same stimulus -> outputs 0..63 in order; first out_valid on the second edge after the transfer of 63.
REQ-034 PINGPONG_EN, three blocks streamed back-to-back with out_ready=1 -> in_ready stays 1, 192 outputs with no out_valid gaps after the first.
REQ-035 out_ready toggles 1,0,0,1 throughout -> no sample lost or duplicated; out_data stable while stalled.
REQ-036 PINGPONG_EN undefined -> in_ready=0 after the 64th write until the 64th output transfer.
REQ-037 rst_n pulsed low after 30 input transfers -> out_valid=0, then a fresh 64-sample block reads out correctly.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared constants, mode encodings and bank-state type for the IDCT transpose buffer.
package idct_pkg;

  localparam int IDCT_W = 16;
  localparam int IDCT_N = 8;

  localparam logic [1:0] MODE_ROW = 2'b00;
  localparam logic [1:0] MODE_COL = 2'b01;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'b00,
    BANK_FILLING  = 2'b01,
    BANK_FULL     = 2'b10,
    BANK_DRAINING = 2'b11
  } bank_st_e;

  // Column readout swaps the row/column halves of the 8x8 index.
  function automatic logic [5:0] rd_addr(input logic [5:0] idx, input logic [1:0] m);
    logic [5:0] a;
    if (m == MODE_COL) begin
      a = {idx[2:0], idx[5:3]};
    end else begin
      a = idx;
    end
    return a;
  endfunction

endpackage

// File: rtl/idct_tbuf_ram.sv
// One block of sample storage: synchronous write port, combinational read port.
module idct_tbuf_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/idct_transpose_buf.sv
// Block reorder buffer between idct_line passes: row-major in, row or column order out.
// Define IDCT_TRANSPOSE_PINGPONG_EN for two banks (overlapped write/readout); default is one bank.
module idct_transpose_buf
  import idct_pkg::*;
#(
  parameter int W = IDCT_W,
  parameter int N = IDCT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);

`ifdef IDCT_TRANSPOSE_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic [5:0]   wr_idx_r, rd_idx_r;
  logic         wr_bank_r, rd_bank_r, wr_bank_s, rd_bank_s;
  logic         in_ready_r, in_ready_s;
  bank_st_e     st_r [NB];
  bank_st_e     st_s [NB];
  logic [1:0]   mode_r [NB];
  logic [W-1:0] rdata_s [NB];
  logic [1:0]   mode_norm_s;
  logic         in_xfer_s, load_s;
  logic [5:0]   raddr_s;
  logic         out_valid_r, out_last_r;
  logic [W-1:0] out_data_r;

  assign in_xfer_s   = in_valid && in_ready_r;
  assign load_s      = (!out_valid_r || out_ready) &&
                       ((st_r[rd_bank_r] == BANK_FULL) || (st_r[rd_bank_r] == BANK_DRAINING));
  assign mode_norm_s = (mode == MODE_ROW) ? MODE_ROW : MODE_COL;
  assign raddr_s     = rd_addr(rd_idx_r, mode_r[rd_bank_r]);

`ifdef IDCT_TRANSPOSE_PINGPONG_EN
  assign wr_bank_s = (in_xfer_s && (wr_idx_r == 6'd63)) ? ~wr_bank_r : wr_bank_r;
  assign rd_bank_s = (load_s && (rd_idx_r == 6'd63)) ? ~rd_bank_r : rd_bank_r;
`else
  assign wr_bank_s = 1'b0;
  assign rd_bank_s = 1'b0;
`endif

  for (genvar b = 0; b < NB; b++) begin : g_bank
    idct_tbuf_ram #(.W(W), .DEPTH(N * N)) u_ram (
      .clk   (clk),
      .we    (in_xfer_s && (wr_bank_r == 1'(b))),
      .waddr (wr_idx_r),
      .wdata (in_data),
      .raddr (raddr_s),
      .rdata (rdata_s[b])
    );
  end

  // Bank state next-value; a write and a read never target the same bank in one cycle.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      st_s[b] = st_r[b];
      if (in_xfer_s && (wr_bank_r == 1'(b))) begin
        st_s[b] = (wr_idx_r == 6'd63) ? BANK_FULL : BANK_FILLING;
      end else if (load_s && (rd_bank_r == 1'(b))) begin
        st_s[b] = (rd_idx_r == 6'd63) ? BANK_EMPTY : BANK_DRAINING;
      end else begin
        st_s[b] = st_r[b];
      end
    end
    in_ready_s = (st_s[wr_bank_s] == BANK_EMPTY) || (st_s[wr_bank_s] == BANK_FILLING);
  end

  // Index, bank pointer, bank state and per-block mode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_r   <= 6'd0;
      rd_idx_r   <= 6'd0;
      wr_bank_r  <= 1'b0;
      rd_bank_r  <= 1'b0;
      in_ready_r <= 1'b1;
      for (int b = 0; b < NB; b++) begin
        st_r[b]   <= BANK_EMPTY;
        mode_r[b] <= MODE_ROW;
      end
    end else begin
      wr_bank_r  <= wr_bank_s;
      rd_bank_r  <= rd_bank_s;
      in_ready_r <= in_ready_s;
      if (in_xfer_s) begin
        wr_idx_r <= wr_idx_r + 6'd1;
      end
      if (load_s) begin
        rd_idx_r <= rd_idx_r + 6'd1;
      end
      for (int b = 0; b < NB; b++) begin
        st_r[b] <= st_s[b];
        if (in_xfer_s && (wr_bank_r == 1'(b)) && (wr_idx_r == 6'd0)) begin
          mode_r[b] <= mode_norm_s;
        end
      end
    end
  end

  // Output register: loads from the read bank, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_last_r  <= (rd_idx_r == 6'd63);
      out_data_r  <= rdata_s[rd_bank_r];
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_idct_transpose_buf.sv
// Directed, table-driven bench for idct_transpose_buf (row/column readout, stalls, reset).
module tb_idct_transpose_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [1:0]  mode;
    int          nblk;
    bit          stall;
    logic [15:0] base;
    logic [15:0] e1;
    logic [15:0] e8;
    logic [15:0] e63;
  } vec_t;

  vec_t tbl [5];

  idct_transpose_buf #(.W(16), .N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_addr(input int j, input bit col);
    return col ? ((j % 8) * 8 + (j / 8)) : j;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int          n_tot, in_cnt, out_cnt, cyc, t_in_last, t_first_ov;
    int          gaps, ir_drops, blk_viol;
    bit          blocked, started, stalled_prev, col;
    logic [15:0] hold_d;
    logic        hold_l;
    logic [1:0]  alt;
    logic [15:0] got_d [$];
    bit          got_l [$];
    n_tot = v.nblk * 64;
    in_cnt = 0; out_cnt = 0; cyc = 0; t_in_last = -1; t_first_ov = -1;
    gaps = 0; ir_drops = 0; blk_viol = 0;
    blocked = 1'b0; started = 1'b0; stalled_prev = 1'b0;
    hold_d = 16'h0000; hold_l = 1'b0;
    alt = (v.mode == 2'b00) ? 2'b01 : 2'b00;
    col = (v.mode != 2'b00);
    while ((out_cnt < n_tot) && (cyc < 4000)) begin
      in_valid  = (in_cnt < n_tot);
      in_data   = v.base + 16'(in_cnt);
      mode      = ((in_cnt % 64) == 0) ? v.mode : alt;
      out_ready = v.stall ? (((cyc % 4) == 0) || ((cyc % 4) == 3)) : 1'b1;
      if (stalled_prev) begin
        chk($sformatf("v%0d stall_hold c%0d", id, cyc), {out_valid, out_last, out_data},
            {1'b1, hold_l, hold_d});
      end
      if (started && !out_valid) gaps++;
      if (in_valid && !in_ready && !v.stall) ir_drops++;
      if (blocked) begin
        if (out_valid && out_last) blocked = 1'b0;
        else if (in_ready) blk_viol++;
      end
      if (out_valid && (t_first_ov < 0)) begin
        t_first_ov = cyc;
        started = 1'b1;
      end
      if (in_valid && in_ready) begin
        in_cnt++;
        if (in_cnt == 64) t_in_last = cyc;
        if ((in_cnt % 64) == 0) blocked = 1'b1;
      end
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        out_cnt++;
        if (out_cnt == n_tot) started = 1'b0;
      end
      stalled_prev = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk($sformatf("v%0d timeout", id), 32'(cyc < 4000), 32'd1);
    chk($sformatf("v%0d out_count", id), out_cnt, n_tot);
    for (int n = 0; n < got_d.size(); n++) begin
      chk($sformatf("v%0d data[%0d]", id, n), got_d[n],
          v.base + 16'((n / 64) * 64 + exp_addr(n % 64, col)));
      chk($sformatf("v%0d last[%0d]", id, n), 32'(got_l[n]), 32'((n % 64) == 63));
    end
    if (got_d.size() > 63) begin
      chk($sformatf("v%0d hand[1]", id), got_d[1], v.e1);
      chk($sformatf("v%0d hand[8]", id), got_d[8], v.e8);
      chk($sformatf("v%0d hand[63]", id), got_d[63], v.e63);
    end
    chk($sformatf("v%0d latency", id), t_first_ov, t_in_last + 2);
`ifdef IDCT_TRANSPOSE_PINGPONG_EN
    if (!v.stall) begin
      chk($sformatf("v%0d out_gaps", id), gaps, 0);
      chk($sformatf("v%0d in_ready_drops", id), ir_drops, 0);
    end
`else
    chk($sformatf("v%0d in_ready_while_full", id), blk_viol, 0);
    chk($sformatf("v%0d in_ready_after_drain", id), 32'(in_ready), 32'd1);
`endif
  endtask

  initial begin
    vec_t rv;
    tbl[0] = '{2'b01, 1, 1'b0, 16'h0000, 16'h0008, 16'h0001, 16'h003F};
    tbl[1] = '{2'b00, 1, 1'b0, 16'h0000, 16'h0001, 16'h0008, 16'h003F};
    tbl[2] = '{2'b10, 1, 1'b1, 16'h0100, 16'h0108, 16'h0101, 16'h013F};
    tbl[3] = '{2'b00, 3, 1'b0, 16'h0200, 16'h0201, 16'h0208, 16'h023F};
    tbl[4] = '{2'b11, 2, 1'b1, 16'h0400, 16'h0408, 16'h0401, 16'h043F};

    rst_n = 1'b0; mode = 2'b00; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_last", 32'(out_last), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 5; i++) begin
      run_vec(tbl[i], i);
      repeat (3) @(posedge clk);
      #1;
    end

    // Partial block followed by a mid-block reset must leave no trace.
    in_valid = 1'b1; mode = 2'b00; out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      in_data = 16'h0700 + 16'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset out_data", out_data, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset idle out_valid", 32'(out_valid), 32'd0);
    rv = '{2'b01, 1, 1'b0, 16'h0900, 16'h0908, 16'h0901, 16'h093F};
    run_vec(rv, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
